// File: rtl/pe_pkg.sv
// Shared types and constant helpers for the systolic MAC processing element.
// Saturation bounds are computed at the widest supported accumulator width and sliced by users.
package pe_pkg;

   localparam int CHAIN_W = 64;

   typedef struct packed {
      logic [CHAIN_W-1:0] value;
      logic               valid;
      logic               ovf;
   } chain_t;

   function automatic logic [CHAIN_W-1:0] sat_max(input int width, input bit is_signed);
      logic [CHAIN_W-1:0] ones;
      ones = '1;
      if (is_signed)
         return ones >> (CHAIN_W - width + 1);
      return ones >> (CHAIN_W - width);
   endfunction

   function automatic logic [CHAIN_W-1:0] sat_min(input int width, input bit is_signed);
      logic [CHAIN_W-1:0] one;
      one = 1;
      if (is_signed)
         return one << (width - 1);
      return '0;
   endfunction

   // Accumulator must hold a full product and still fit the drain-chain value field.
   function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w);
      return (acc_w >= a_w + b_w) && (acc_w < CHAIN_W);
   endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational multiply-accumulate step: product, one-bit-wider sum, overflow detect
// and clamp-or-wrap of the result back to the accumulator width.
module pe_mac_sat
   import pe_pkg::*;
#(
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 24,
   parameter int SIGNED    = 1,
   parameter int SATURATE  = 1
) (
   input  logic                 en,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 ovf
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;
   localparam logic [CHAIN_W-1:0] MAX_FULL = sat_max(ACC_WIDTH, SIGNED != 0);
   localparam logic [CHAIN_W-1:0] MIN_FULL = sat_min(ACC_WIDTH, SIGNED != 0);
   localparam logic [ACC_WIDTH-1:0] MAX_V = MAX_FULL[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] MIN_V = MIN_FULL[ACC_WIDTH-1:0];

   logic               a_ext;
   logic               b_ext;
   logic               p_ext;
   logic               acc_ext;
   logic [P_WIDTH-1:0] a_x;
   logic [P_WIDTH-1:0] b_x;
   logic [P_WIDTH-1:0] prod;
   logic [ACC_WIDTH:0] prod_x;
   logic [ACC_WIDTH:0] acc_x;
   logic [ACC_WIDTH:0] total;

   // Extending both operands to the product width makes the low P bits correct in either mode.
   assign a_ext   = (SIGNED != 0) & a[A_WIDTH-1];
   assign b_ext   = (SIGNED != 0) & b[B_WIDTH-1];
   assign a_x     = {{B_WIDTH{a_ext}}, a};
   assign b_x     = {{A_WIDTH{b_ext}}, b};
   assign prod    = a_x * b_x;

   assign p_ext   = (SIGNED != 0) & prod[P_WIDTH-1];
   assign acc_ext = (SIGNED != 0) & acc[ACC_WIDTH-1];
   assign prod_x  = en ? {{(ACC_WIDTH + 1 - P_WIDTH){p_ext}}, prod} : '0;
   assign acc_x   = {acc_ext, acc};
   assign total   = acc_x + prod_x;

   assign ovf = (SIGNED != 0) ? (total[ACC_WIDTH] ^ total[ACC_WIDTH-1]) : total[ACC_WIDTH];

   always_comb begin
      sum = total[ACC_WIDTH-1:0];
      if (ovf && (SATURATE != 0))
         sum = ((SIGNED != 0) && total[ACC_WIDTH]) ? MIN_V : MAX_V;
   end

endmodule

// File: rtl/pe_mac_drain.sv
// Output-stationary systolic PE: forwards operands, accumulates products and hands
// finished tiles to a double-buffered result register on the per-column drain chain.
module pe_mac_drain
   import pe_pkg::*;
#(
   parameter int A_WIDTH   = 8,
   parameter int B_WIDTH   = 8,
   parameter int ACC_WIDTH = 24,
   parameter int SIGNED    = 1,
   parameter int SATURATE  = 1,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic [A_WIDTH-1:0]   a_in,
   input  logic [B_WIDTH-1:0]   b_in,
   output logic [A_WIDTH-1:0]   a_out,
   output logic [B_WIDTH-1:0]   b_out,
   output logic                 out_valid,
   input  logic                 drain,
   input  logic                 shift,
   input  logic [ACC_WIDTH-1:0] c_in,
   input  logic                 c_valid_in,
   input  logic                 c_ovf_in,
   output logic [ACC_WIDTH-1:0] c_out,
   output logic                 c_valid,
   output logic                 c_ovf,
   output logic [CNT_WIDTH-1:0] c_count,
   output logic                 ovf
);

   if (!widths_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_width_check
      $error("pe_mac_drain: ACC_WIDTH must be >= A_WIDTH+B_WIDTH and < %0d", CHAIN_W);
   end

   logic [ACC_WIDTH-1:0] acc_reg;
   logic [ACC_WIDTH-1:0] acc_next;
   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 ovf_reg;
   logic                 ovf_next;
   logic                 mac_ovf;
   logic [A_WIDTH-1:0]   a_reg;
   logic [B_WIDTH-1:0]   b_reg;
   logic                 valid_reg;
   chain_t               res_reg;
   chain_t               res_next;
   logic [CNT_WIDTH-1:0] count_reg;
   logic [CNT_WIDTH-1:0] count_next;
   logic                 unused_hi;

   pe_mac_sat #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SIGNED    (SIGNED),
      .SATURATE  (SATURATE)
   ) u_mac (
      .en  (in_valid),
      .a   (a_in),
      .b   (b_in),
      .acc (acc_reg),
      .sum (acc_next),
      .ovf (mac_ovf)
   );

   assign ovf_next = ovf_reg | mac_ovf;

   // The MAC counter sticks at all-ones rather than wrapping.
   always_comb begin
      cnt_next = cnt_reg;
      if (in_valid && !(&cnt_reg))
         cnt_next = cnt_reg + 1'b1;
   end

   always_comb begin
      res_next   = res_reg;
      count_next = count_reg;
      if (drain) begin
         res_next.valid = 1'b1;
         if (clear) begin
            res_next.value = '0;
            res_next.ovf   = 1'b0;
            count_next     = '0;
         end else begin
            res_next.value = CHAIN_W'(acc_next);
            res_next.ovf   = ovf_next;
            count_next     = cnt_next;
         end
      end else if (shift) begin
         res_next.value = CHAIN_W'(c_in);
         res_next.valid = c_valid_in;
         res_next.ovf   = c_ovf_in;
         count_next     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg   <= '0;
         cnt_reg   <= '0;
         ovf_reg   <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         valid_reg <= 1'b0;
         res_reg   <= '0;
         count_reg <= '0;
      end else begin
         valid_reg <= in_valid & ~clear;
         if (clear) begin
            a_reg <= '0;
            b_reg <= '0;
         end else if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
         end
         // Draining restarts accumulation on the same edge the result is captured.
         if (clear || drain) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
         end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
         end
         res_reg   <= res_next;
         count_reg <= count_next;
      end
   end

   assign unused_hi = ^res_reg.value[CHAIN_W-1:ACC_WIDTH];

   assign a_out     = a_reg;
   assign b_out     = b_reg;
   assign out_valid = valid_reg;
   assign c_out     = res_reg.value[ACC_WIDTH-1:0];
   assign c_valid   = res_reg.valid;
   assign c_ovf     = res_reg.ovf;
   assign c_count   = count_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pe_mac_drain.sv
// Directed bench for pe_mac_drain: a default PE, a 3-PE drain chain and an unsigned
// wrapping PE, with drained results checked against a scoreboard queue.
module tb_pe_mac_drain;

   logic clk;
   logic rst;

   // Default-parameter PE
   logic        d_clear, d_in_valid, d_drain, d_shift, d_c_valid_in, d_c_ovf_in;
   logic [7:0]  d_a_in, d_b_in, d_a_out, d_b_out;
   logic        d_out_valid, d_c_valid, d_c_ovf, d_ovf;
   logic [23:0] d_c_in, d_c_out;
   logic [7:0]  d_c_count;

   // Three-PE drain chain, element 2 is the tail
   logic        ch_clear, ch_drain, ch_shift;
   logic [2:0]  ch_in_valid;
   logic [7:0]  ch_a [3];
   logic [7:0]  ch_b [3];
   logic [7:0]  ch_a_out [3];
   logic [7:0]  ch_b_out [3];
   logic [2:0]  ch_out_valid, ch_c_valid, ch_c_ovf, ch_ovf, ch_cvi, ch_coi;
   logic [23:0] ch_cin [3];
   logic [23:0] ch_c_out [3];
   logic [7:0]  ch_c_count [3];

   // Unsigned, wrapping, 16-bit accumulator PE
   logic        u_clear, u_in_valid, u_drain, u_shift, u_c_valid_in, u_c_ovf_in;
   logic [7:0]  u_a_in, u_b_in, u_a_out, u_b_out;
   logic        u_out_valid, u_c_valid, u_c_ovf, u_ovf;
   logic [15:0] u_c_in, u_c_out;
   logic [7:0]  u_c_count;

   int checks;
   int errors;

   typedef struct {
      logic [63:0] val;
      logic        ovf;
      logic [7:0]  cnt;
   } exp_t;
   exp_t sb[$];

   pe_mac_drain dut (
      .clk(clk), .rst(rst), .clear(d_clear), .in_valid(d_in_valid),
      .a_in(d_a_in), .b_in(d_b_in), .a_out(d_a_out), .b_out(d_b_out),
      .out_valid(d_out_valid), .drain(d_drain), .shift(d_shift),
      .c_in(d_c_in), .c_valid_in(d_c_valid_in), .c_ovf_in(d_c_ovf_in),
      .c_out(d_c_out), .c_valid(d_c_valid), .c_ovf(d_c_ovf),
      .c_count(d_c_count), .ovf(d_ovf)
   );

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chain
         if (gi == 0) begin : g_head
            assign ch_cin[gi] = '0;
            assign ch_cvi[gi] = 1'b0;
            assign ch_coi[gi] = 1'b0;
         end else begin : g_body
            assign ch_cin[gi] = ch_c_out[gi-1];
            assign ch_cvi[gi] = ch_c_valid[gi-1];
            assign ch_coi[gi] = ch_c_ovf[gi-1];
         end
         pe_mac_drain u_pe (
            .clk(clk), .rst(rst), .clear(ch_clear), .in_valid(ch_in_valid[gi]),
            .a_in(ch_a[gi]), .b_in(ch_b[gi]), .a_out(ch_a_out[gi]), .b_out(ch_b_out[gi]),
            .out_valid(ch_out_valid[gi]), .drain(ch_drain), .shift(ch_shift),
            .c_in(ch_cin[gi]), .c_valid_in(ch_cvi[gi]), .c_ovf_in(ch_coi[gi]),
            .c_out(ch_c_out[gi]), .c_valid(ch_c_valid[gi]), .c_ovf(ch_c_ovf[gi]),
            .c_count(ch_c_count[gi]), .ovf(ch_ovf[gi])
         );
      end
   endgenerate

   pe_mac_drain #(
      .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0), .CNT_WIDTH(8)
   ) dutu (
      .clk(clk), .rst(rst), .clear(u_clear), .in_valid(u_in_valid),
      .a_in(u_a_in), .b_in(u_b_in), .a_out(u_a_out), .b_out(u_b_out),
      .out_valid(u_out_valid), .drain(u_drain), .shift(u_shift),
      .c_in(u_c_in), .c_valid_in(u_c_valid_in), .c_ovf_in(u_c_ovf_in),
      .c_out(u_c_out), .c_valid(u_c_valid), .c_ovf(u_c_ovf),
      .c_count(u_c_count), .ovf(u_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_result(input logic [63:0] v, input logic o, input logic [7:0] c);
      exp_t e;
      e.val = v;
      e.ovf = o;
      e.cnt = c;
      sb.push_back(e);
   endtask

   task automatic sb_check(input string tag, input logic [63:0] v, input logic o,
                           input logic [7:0] c, input logic vld);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed c_out %0d expected no pending result", tag, v);
      end else begin
         e = sb.pop_front();
         $display("txn %s: c_out=%0d c_ovf=%0d c_count=%0d c_valid=%0d (exp %0d/%0d/%0d/1)",
                  tag, v, o, c, vld, e.val, e.ovf, e.cnt);
         check({tag, ".c_out"}, v, e.val);
         check({tag, ".c_ovf"}, 64'(o), 64'(e.ovf));
         check({tag, ".c_count"}, 64'(c), 64'(e.cnt));
         check({tag, ".c_valid"}, 64'(vld), 64'd1);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      d_clear = 0; d_in_valid = 0; d_drain = 0; d_shift = 0; d_c_valid_in = 0; d_c_ovf_in = 0;
      d_a_in = 0; d_b_in = 0; d_c_in = 0;
      ch_clear = 0; ch_drain = 0; ch_shift = 0; ch_in_valid = '0;
      for (int i = 0; i < 3; i++) begin
         ch_a[i] = 0;
         ch_b[i] = 0;
      end
      u_clear = 0; u_in_valid = 0; u_drain = 0; u_shift = 0; u_c_valid_in = 0; u_c_ovf_in = 0;
      u_a_in = 0; u_b_in = 0; u_c_in = 0;

      // Reset state
      tick();
      tick();
      check("reset.c_out", d_c_out, 0);
      check("reset.c_valid", d_c_valid, 0);
      check("reset.c_ovf", d_c_ovf, 0);
      check("reset.c_count", d_c_count, 0);
      check("reset.ovf", d_ovf, 0);
      check("reset.out_valid", d_out_valid, 0);
      check("reset.a_out", d_a_out, 0);
      rst = 1'b0;

      // Three MACs of 3*4, the third in the drain cycle
      d_in_valid = 1; d_a_in = 8'd3; d_b_in = 8'd4;
      tick();
      check("fwd.out_valid", d_out_valid, 1);
      check("fwd.a_out", d_a_out, 3);
      check("fwd.b_out", d_b_out, 4);
      tick();
      d_drain = 1;
      expect_result(36, 0, 3);
      tick();
      d_drain = 0;
      sb_check("drain_36", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Asynchronous reset mid-tile, between clock edges
      tick();
      d_in_valid = 0;
      #2 rst = 1'b1;
      #1;
      check("async_rst.c_out", d_c_out, 0);
      check("async_rst.c_valid", d_c_valid, 0);
      check("async_rst.a_out", d_a_out, 0);
      check("async_rst.out_valid", d_out_valid, 0);
      #1 rst = 1'b0;
      d_drain = 1;
      expect_result(0, 0, 0);
      tick();
      d_drain = 0;
      sb_check("drain_after_rst", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Valid gating
      d_in_valid = 1; d_a_in = 8'd5; d_b_in = 8'd2;
      tick();
      d_in_valid = 0; d_a_in = 8'd7; d_b_in = 8'd9;
      tick();
      check("gate.a_out_hold", d_a_out, 5);
      check("gate.b_out_hold", d_b_out, 2);
      check("gate.out_valid_low", d_out_valid, 0);
      d_in_valid = 1;
      tick();
      check("gate.out_valid_high", d_out_valid, 1);
      check("gate.a_out_load", d_a_out, 7);
      d_in_valid = 0; d_drain = 1;
      expect_result(73, 0, 2);
      tick();
      d_drain = 0;
      sb_check("drain_73", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Drain includes the product presented in the same cycle
      d_in_valid = 1; d_a_in = 8'd10; d_b_in = 8'd1;
      tick();
      d_a_in = 8'd2; d_b_in = 8'd3; d_drain = 1;
      expect_result(16, 0, 2);
      tick();
      d_drain = 0; d_in_valid = 0;
      sb_check("drain_same_cycle", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Clear alone leaves the result register untouched
      d_in_valid = 1; d_a_in = 8'd3; d_b_in = 8'd3;
      tick();
      d_clear = 1; d_a_in = 8'd4; d_b_in = 8'd4;
      tick();
      d_clear = 0; d_in_valid = 0;
      check("clear.c_out_kept", d_c_out, 16);
      check("clear.c_valid_kept", d_c_valid, 1);
      check("clear.out_valid", d_out_valid, 0);
      check("clear.a_out", d_a_out, 0);
      d_drain = 1;
      expect_result(0, 0, 0);
      tick();
      d_drain = 0;
      sb_check("drain_after_clear", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Clear and drain together
      d_in_valid = 1; d_a_in = 8'd3; d_b_in = 8'd3;
      tick();
      d_clear = 1; d_drain = 1;
      expect_result(0, 0, 0);
      tick();
      d_clear = 0; d_drain = 0; d_in_valid = 0;
      sb_check("clear_drain", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Shift loads the upstream result, then holds
      d_shift = 1; d_c_in = 24'd123; d_c_valid_in = 1; d_c_ovf_in = 1;
      expect_result(123, 1, 0);
      tick();
      d_shift = 0; d_c_in = 24'd99;
      sb_check("shift_in", d_c_out, d_c_ovf, d_c_count, d_c_valid);
      tick();
      check("hold.c_out", d_c_out, 123);

      // Positive saturation: 512 * 16384 first exceeds 8388607
      d_in_valid = 1; d_a_in = 8'h80; d_b_in = 8'h80;
      for (int i = 0; i < 511; i++) tick();
      check("sat.ovf_before", d_ovf, 0);
      tick();
      check("sat.ovf_at", d_ovf, 1);
      for (int i = 0; i < 88; i++) tick();
      d_in_valid = 0; d_drain = 1;
      expect_result(64'd8388607, 1, 255);
      tick();
      d_drain = 0;
      sb_check("drain_sat_max", d_c_out, d_c_ovf, d_c_count, d_c_valid);
      check("sat.ovf_cleared", d_ovf, 0);

      // Negative saturation
      d_in_valid = 1; d_a_in = 8'h80; d_b_in = 8'h7f;
      for (int i = 0; i < 600; i++) tick();
      d_in_valid = 0; d_drain = 1;
      expect_result(64'h800000, 1, 255);
      tick();
      d_drain = 0;
      sb_check("drain_sat_min", d_c_out, d_c_ovf, d_c_count, d_c_valid);

      // Unsigned wrap: 2 * 65025 mod 65536
      u_in_valid = 1; u_a_in = 8'd255; u_b_in = 8'd255;
      tick();
      check("wrap.ovf_first", u_ovf, 0);
      tick();
      check("wrap.ovf_second", u_ovf, 1);
      u_in_valid = 0; u_drain = 1;
      expect_result(64514, 1, 2);
      tick();
      u_drain = 0;
      sb_check("drain_wrap", u_c_out, u_c_ovf, u_c_count, u_c_valid);
      check("wrap.ovf_cleared", u_ovf, 0);

      // Drain chain: 5, 6, 7 drained together, shifted out of the tail
      ch_in_valid = 3'b111;
      ch_a[0] = 8'd5; ch_a[1] = 8'd6; ch_a[2] = 8'd7;
      ch_b[0] = 8'd1; ch_b[1] = 8'd1; ch_b[2] = 8'd1;
      ch_drain = 1;
      expect_result(7, 0, 1);
      tick();
      ch_drain = 0; ch_in_valid = '0;
      sb_check("chain_tail0", ch_c_out[2], ch_c_ovf[2], ch_c_count[2], ch_c_valid[2]);
      ch_shift = 1;
      expect_result(6, 0, 0);
      tick();
      sb_check("chain_tail1", ch_c_out[2], ch_c_ovf[2], ch_c_count[2], ch_c_valid[2]);
      expect_result(5, 0, 0);
      tick();
      sb_check("chain_tail2", ch_c_out[2], ch_c_ovf[2], ch_c_count[2], ch_c_valid[2]);
      tick();
      ch_shift = 0;
      check("chain.tail_empty", ch_c_valid[2], 0);

      check("scoreboard.drained", 64'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
